// File: rtl/tick_scheduler.sv
// Programmable per-channel clock-enable scheduler on clk_54mhz.
// Divisors load through a valid/ready port and apply only at period boundaries or on sync.
module tick_scheduler #(
  parameter int NCH         = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_54mhz,
  input  logic             restart_n,
  input  logic             enable,
  input  logic             sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_chan,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   active
);

  localparam logic [CW:0]      NCH_V = (CW+1)'(NCH);
  localparam logic [DIV_W-1:0] DEF_V = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt    [NCH];
  logic [DIV_W-1:0] div    [NCH];
  logic [DIV_W-1:0] shadow [NCH];
  logic [NCH-1:0]   pend;

  logic [DIV_W-1:0] cnt_n    [NCH];
  logic [DIV_W-1:0] div_n    [NCH];
  logic [DIV_W-1:0] shadow_n [NCH];
  logic [NCH-1:0]   pend_n;
  logic [NCH-1:0]   tick_n;
  logic [NCH-1:0]   active_n;
  logic             cfg_err_n;
  logic             chan_ok;
  logic             accept;
  logic             wrap;

  assign chan_ok = ({1'b0, cfg_chan} < NCH_V);

  // Out-of-range channels are always ready so the request can complete with an error.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cfg_chan == CW'(i) && pend[i]) cfg_ready = 1'b0;
    end
  end

  assign accept = cfg_valid & cfg_ready;

  always_comb begin
    cfg_err_n = accept & ~chan_ok;
    pend_n    = pend;
    tick_n    = '0;
    active_n  = '0;
    wrap      = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_n[i]    = cnt[i];
      div_n[i]    = div[i];
      shadow_n[i] = shadow[i];
      wrap        = 1'b0;
      if (sync || div[i] == '0) begin
        cnt_n[i] = '0;
      end else if (enable) begin
        if (cnt[i] == div[i] - 1'b1) begin
          cnt_n[i]  = '0;
          tick_n[i] = 1'b1;
          wrap      = 1'b1;
        end else begin
          cnt_n[i] = cnt[i] + 1'b1;
        end
      end
      if (pend[i] && (sync || div[i] == '0 || wrap)) begin
        div_n[i]  = shadow[i];
        pend_n[i] = 1'b0;
      end
      if (accept && chan_ok && cfg_chan == CW'(i)) begin
        shadow_n[i] = cfg_div;
        pend_n[i]   = 1'b1;
      end
      active_n[i] = (div_n[i] != '0);
    end
  end

  always_ff @(posedge clk_54mhz or negedge restart_n) begin
    if (!restart_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        div[i]    <= DEF_V;
        shadow[i] <= '0;
      end
      pend    <= '0;
      tick    <= '0;
      active  <= (DEFAULT_DIV != 0) ? '1 : '0;
      cfg_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]    <= cnt_n[i];
        div[i]    <= div_n[i];
        shadow[i] <= shadow_n[i];
      end
      pend    <= pend_n;
      tick    <= tick_n;
      active  <= active_n;
      cfg_err <= cfg_err_n;
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler (NCH=3, DIV_W=8): directed scenarios then random traffic,
// checked against a countdown model of each channel's period.
module tb_tick_scheduler;

  localparam int NCH = 3;

  logic       clk = 1'b0;
  logic       restart_n = 1'b0;
  logic       enable = 1'b0;
  logic       sync = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_chan = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_err;
  logic [2:0] tick;
  logic [2:0] active;

  int checks = 0;
  int failures = 0;

  // Model: m_rem = enabled edges left until this channel's next tick.
  int       m_p   [NCH];
  int       m_rem [NCH];
  int       m_sh  [NCH];
  bit       m_pend[NCH];
  logic [2:0] e_tick;
  logic [2:0] e_act;
  logic       e_err;

  tick_scheduler #(.NCH(3), .DIV_W(8), .DEFAULT_DIV(2)) dut (
    .clk_54mhz(clk),
    .restart_n(restart_n),
    .enable(enable),
    .sync(sync),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .tick(tick),
    .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_p[i] = 2; m_rem[i] = 2; m_sh[i] = 0; m_pend[i] = 0;
    end
    e_tick = '0; e_act = 3'b111; e_err = 1'b0;
  endtask

  function automatic bit exp_ready(input logic [1:0] ch);
    if (ch >= 2'(NCH)) return 1'b1;
    return !m_pend[ch];
  endfunction

  task automatic model_step(input bit en, input bit sy, input bit acc,
                            input logic [1:0] ch, input int d);
    e_err = acc && (ch >= 2'(NCH));
    for (int i = 0; i < NCH; i++) begin
      e_tick[i] = 1'b0;
      if (sy || m_p[i] == 0) begin
        if (m_pend[i]) begin m_p[i] = m_sh[i]; m_pend[i] = 0; end
        m_rem[i] = m_p[i];
      end else if (en) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          e_tick[i] = 1'b1;
          if (m_pend[i]) begin m_p[i] = m_sh[i]; m_pend[i] = 0; end
          m_rem[i] = m_p[i];
        end
      end
      if (acc && ch == 2'(i)) begin m_sh[i] = d; m_pend[i] = 1; end
      e_act[i] = (m_p[i] != 0);
    end
  endtask

  // One clock: drive at negedge, check ready, update model at posedge, check outputs.
  task automatic cyc(input bit en, input bit sy, input bit v,
                     input logic [1:0] ch, input logic [7:0] d);
    bit r;
    enable = en; sync = sy; cfg_valid = v; cfg_chan = ch; cfg_div = d;
    #1;
    r = exp_ready(ch);
    chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, r});
    @(posedge clk);
    model_step(en, sy, v && r, ch, int'(d));
    @(negedge clk);
    chk("tick", {29'b0, tick}, {29'b0, e_tick});
    chk("active", {29'b0, active}, {29'b0, e_act});
    chk("cfg_err", {31'b0, cfg_err}, {31'b0, e_err});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    restart_n = 1'b0;
    #1;
    model_reset();
    chk("rst_tick", {29'b0, tick}, 32'h0);
    chk("rst_active", {29'b0, active}, 32'h7);
    chk("rst_cfg_err", {31'b0, cfg_err}, 32'h0);
    @(negedge clk);
    restart_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    enable = 1'b1;
    #1;
    chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'h1);

    // Default divisor 2 on every channel.
    run(4);
    // Reprogram ch1 to 5 while it is mid-period.
    cyc(1'b1, 1'b0, 1'b1, 2'd1, 8'd5);
    for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0, 1'b0, 2'd1, 8'd0);
    // ch2 off, then back on at 3 (immediate apply).
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 8'd0);
    run(4);
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 8'd3);
    run(8);
    // Out-of-range channel: one-cycle error pulse.
    cyc(1'b1, 1'b0, 1'b1, 2'd3, 8'd7);
    chk("err_pulse", {31'b0, cfg_err}, 32'h1);
    run(1);
    chk("err_clear", {31'b0, cfg_err}, 32'h0);
    // ch0 to 4, then a pending ch1 value applied at sync.
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'd4);
    run(7);
    cyc(1'b1, 1'b0, 1'b1, 2'd1, 8'd6);
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    chk("sync_tick", {29'b0, tick}, 32'h0);
    run(10);
    // Sync together with an accept: the accept waits for the next wrap.
    cyc(1'b1, 1'b1, 1'b1, 2'd2, 8'd2);
    run(8);
    // Freeze with enable=0.
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'd3);
    run(5);
    for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("frozen_tick", {29'b0, tick}, 32'h0);
    run(6);
    // Config accepted while frozen.
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'd1);
    run(6);
    // Boundary divisors 1 and 255.
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'd1);
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 8'd255);
    run(530);
    do_reset();
    run(6);

    // Random traffic with occasional async reset.
    for (int k = 0; k < 4000; k++) begin
      bit en, sy, v;
      logic [1:0] ch;
      logic [7:0] d;
      en = ($urandom % 8) != 0;
      sy = ($urandom % 50) == 0;
      v  = ($urandom % 4) == 0;
      ch = 2'($urandom % 4);
      case ($urandom % 10)
        0:       d = 8'd0;
        1:       d = 8'd1;
        2:       d = 8'($urandom_range(10, 40));
        default: d = 8'($urandom_range(2, 9));
      endcase
      cyc(en, sy, v, ch, d);
      if (($urandom % 1500) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
